// File: rtl/boss_pkg.sv
// Shared types and constants for the boss attack scheduler: FSM state encoding,
// motion-pattern magnitude table and default slot count.
package boss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_COOL = 3'd1,
    ST_PICK = 3'd2,
    ST_FIRE = 3'd3,
    ST_GAP  = 3'd4
  } sched_state_t;

  localparam int DEFAULT_NUM_SLOTS = 5;
  localparam int PATTERN_COUNT     = 5;

  // Index [p][0] is the X magnitude, [p][1] the Y magnitude.
  localparam logic [9:0] PATTERN_MAG [PATTERN_COUNT][2] = '{
    '{10'd4,  10'd10},
    '{10'd4,  10'd8},
    '{10'd4,  10'd4},
    '{10'd8,  10'd4},
    '{10'd10, 10'd4}
  };

  function automatic logic [9:0] neg10(input logic [9:0] mag);
    return (~mag) + 10'd1;
  endfunction

endpackage

// File: rtl/slot_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting slot at or after the
// rotation pointer, wrapping modulo NUM_SLOTS.
module slot_rr_arbiter #(
  parameter int NUM_SLOTS = 5,
  parameter int IW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [IW-1:0]        rr,
  output logic                 grant_valid,
  output logic [IW-1:0]        grant_idx
);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      int idx;
      idx = int'(rr) + k;
      if (idx >= NUM_SLOTS) begin
        idx = idx - NUM_SLOTS;
      end else begin
        idx = idx;
      end
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/boss_attack_scheduler.sv
// Boss volley scheduler: cooldown, round-robin slot pick, spaced launches.
// Optional macro BOSS_ATTACK_RAMP_EN shortens the cooldown as volleys accumulate.
module boss_attack_scheduler
  import boss_pkg::*;
#(
  parameter int NUM_SLOTS   = DEFAULT_NUM_SLOTS,
  parameter int VOLLEY_SIZE = 3,
  parameter int COOLDOWN    = 60,
  parameter int SHOT_GAP    = 4
) (
  input  logic                 frame_clk,
  input  logic                 Reset_n,
  input  logic                 game_active,
  input  logic                 boss_alive,
  input  logic                 kid_hit,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] launch,
  output logic [9:0]           launch_move_X,
  output logic [9:0]           launch_move_Y,
  output logic [2:0]           pattern_idx,
  output logic [7:0]           volley_count,
  output logic                 busy
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam int SW = $clog2(VOLLEY_SIZE + 1);
  localparam int GW = $clog2(SHOT_GAP + 1);

  sched_state_t state, state_d;
  logic [CW-1:0] cool_cnt, cool_d, reload;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [SW-1:0] shots_left, shots_d;
  logic [IW-1:0] rr_ptr, rr_d, grant_idx;
  logic          grant_valid;
  logic [NUM_SLOTS-1:0] launch_d;
  logic [9:0]    move_x_d, move_y_d;
  logic [2:0]    pattern_d;
  logic [7:0]    volley_d;

  slot_rr_arbiter #(.NUM_SLOTS(NUM_SLOTS), .IW(IW)) u_arb (
    .req         (slot_done),
    .rr          (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef BOSS_ATTACK_RAMP_EN
  int ramp_val;
  int ramp_floor;
  always_comb begin
    ramp_val   = (COOLDOWN - 1) - 4 * int'(volley_count);
    ramp_floor = COOLDOWN / 4 - 1;
    if (ramp_val > ramp_floor) begin
      reload = CW'(ramp_val);
    end else begin
      reload = CW'(ramp_floor);
    end
  end
`else
  assign reload = CW'(COOLDOWN - 1);
`endif

  // Abort outranks every state, so a grant in the same frame never pulses.
  always_comb begin
    state_d   = state;
    cool_d    = cool_cnt;
    gap_d     = gap_cnt;
    shots_d   = shots_left;
    rr_d      = rr_ptr;
    launch_d  = '0;
    move_x_d  = launch_move_X;
    move_y_d  = launch_move_Y;
    pattern_d = pattern_idx;
    volley_d  = volley_count;
    if (!(game_active && boss_alive)) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_COOL;
          cool_d  = reload;
        end
        ST_COOL: begin
          if (kid_hit) begin
            cool_d = reload;
          end else if (cool_cnt == '0) begin
            state_d = ST_PICK;
            shots_d = SW'(VOLLEY_SIZE);
          end else begin
            cool_d = cool_cnt - CW'(1);
          end
        end
        ST_PICK: begin
          if (grant_valid) begin
            state_d  = ST_FIRE;
            launch_d = NUM_SLOTS'(1) << grant_idx;
            move_x_d = neg10(PATTERN_MAG[pattern_idx][0]);
            move_y_d = neg10(PATTERN_MAG[pattern_idx][1]);
            if (int'(grant_idx) == NUM_SLOTS - 1) begin
              rr_d = '0;
            end else begin
              rr_d = grant_idx + IW'(1);
            end
          end else begin
            state_d = ST_PICK;
          end
        end
        ST_FIRE: begin
          shots_d = shots_left - SW'(1);
          if (shots_left == SW'(1)) begin
            state_d = ST_COOL;
            cool_d  = reload;
            if (pattern_idx == 3'(PATTERN_COUNT - 1)) begin
              pattern_d = 3'd0;
            end else begin
              pattern_d = pattern_idx + 3'd1;
            end
            if (volley_count == 8'd255) begin
              volley_d = volley_count;
            end else begin
              volley_d = volley_count + 8'd1;
            end
          end else begin
            state_d = ST_GAP;
            gap_d   = GW'(SHOT_GAP - 1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state_d = ST_PICK;
          end else begin
            gap_d = gap_cnt - GW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      cool_cnt      <= '0;
      gap_cnt       <= '0;
      shots_left    <= '0;
      rr_ptr        <= '0;
      launch        <= '0;
      launch_move_X <= 10'd0;
      launch_move_Y <= 10'd0;
      pattern_idx   <= 3'd0;
      volley_count  <= 8'd0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      cool_cnt      <= cool_d;
      gap_cnt       <= gap_d;
      shots_left    <= shots_d;
      rr_ptr        <= rr_d;
      launch        <= launch_d;
      launch_move_X <= move_x_d;
      launch_move_Y <= move_y_d;
      pattern_idx   <= pattern_d;
      volley_count  <= volley_d;
      busy          <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: doc/boss_attack_scheduler.md
Name: boss_attack_scheduler

Overview:
Frame-rate scheduler that decides when the boss fires, which projectile slot fires, and with which motion vector. It owns the pool of ball slots. It round-robins launches across slots that report idle (done), spaces shots within a volley, and enforces a cooldown between volleys. It sits between the boss/game-state logic and the projectile slot instances, and drives each slot's enable and initial-motion inputs.

Parameters:
NUM_SLOTS, 5, number of projectile slots managed (1..8)
VOLLEY_SIZE, 3, shots per volley (1..NUM_SLOTS)
COOLDOWN, 60, frames between end of one volley and start of next (>=4)
SHOT_GAP, 4, frames between consecutive shots within a volley (>=1)

Ports:
frame_clk  in  1  frame-rate clock, all state updates on rising edge
Reset_n  in  1  synchronous active-low reset
game_active  in  1  play in progress; low forces IDLE
boss_alive  in  1  boss present; low forces IDLE
kid_hit  in  1  any slot hit the player this frame (OR of slot hit flags)
slot_done  in  NUM_SLOTS  per-slot idle flag, 1 = slot free to launch
launch  out  NUM_SLOTS  one-hot slot enable pulse, one frame wide
launch_move_X  out  10  initial X motion magnitude for the launched slot, two's complement negative
launch_move_Y  out  10  initial Y motion, same encoding
pattern_idx  out  3  current motion-pattern index 0..4
volley_count  out  8  completed volleys, saturating at 255
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset_n=0 at an edge) sets state=IDLE, launch=0, launch_move_X=0, launch_move_Y=0, pattern_idx=0, volley_count=0, busy=0, rr pointer=0, all counters=0. Reset mid-volley aborts without emitting a pulse.
- States: IDLE, COOL, PICK, FIRE, GAP.
- IDLE: when game_active&boss_alive, go to COOL with cool_cnt=COOLDOWN-1.
- COOL: if cool_cnt==0, go to PICK with shots_left=VOLLEY_SIZE; else decrement.
- PICK: arbiter searches slot_done starting at the rr pointer, wrapping modulo NUM_SLOTS. On a grant, latch slot index, go to FIRE, and set rr=grant+1 mod NUM_SLOTS. With no free slot, stay in PICK indefinitely (stall, no pulse).
- FIRE: launch[slot]=1 for exactly this frame. launch_move_X/Y are driven from the pattern table at pattern_idx and held until the next FIRE. shots_left decrements.
  - If shots_left becomes 0: go to COOL with cool_cnt=COOLDOWN-1; pattern_idx=(pattern_idx+1) mod 5; volley_count++ (saturating).
  - Otherwise: go to GAP with gap_cnt=SHOT_GAP-1.
- GAP: if gap_cnt==0, go to PICK; else decrement.
- Pattern table magnitudes (X,Y): 0:(4,10) 1:(4,8) 2:(4,4) 3:(8,4) 4:(10,4). Outputs carry the negated 10-bit value (e.g. 4 gives 10'h3FC).
- Abort: game_active=0 or boss_alive=0 in any state moves to IDLE at the next edge. launch stays 0 during that frame, and this takes priority over FIRE. pattern_idx and volley_count are retained.
- kid_hit during COOL reloads cool_cnt=COOLDOWN-1 (mercy window). kid_hit is ignored in other states.
- Latency: grant in PICK gives the launch pulse on the next frame. Slot-to-slot spacing within a volley is SHOT_GAP+2 frames when no stall occurs.
- A slot whose slot_done is high in PICK is granted even if it drops done in the same frame. The pulse is still issued.

Optional Feature:
BOSS_ATTACK_RAMP_EN:
- Defined: the cooldown reload value becomes max(COOLDOWN-1 - 4*volley_count, COOLDOWN/4 - 1), evaluated at reload time. The boss gets faster as the fight goes on.
- Undefined: the reload is always COOLDOWN-1.

Decomposition:
- Shared package boss_pkg: sched_state_t enum, pattern magnitude constant array (5 x 2 x 10-bit), pattern count constant 5, default NUM_SLOTS.
- Sub-module slot_rr_arbiter:
  - Inputs: req vector, rr pointer.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational.
  - Instantiated once.

Test Plan:
1. Reset, then game_active=boss_alive=1 with all slot_done=1 and defaults: first launch=5'b00001 at frame 62 after release; launch=5'b00010 6 frames later; 5'b00100 6 frames after that; launch_move_X=10'h3FC and launch_move_Y=10'h3F6 throughout volley 0.
2. After the first volley, volley_count=1 and pattern_idx=1. Next volley starts at slot 3, uses (-4,-8), and slots wrap 3,4,0.
3. All slot_done=0 during PICK for 20 frames: no launch pulses and busy=1. Raising slot_done[2] gives launch=5'b00100 on the following frame.
4. kid_hit pulse at cool_cnt=10: cooldown restarts, and the next launch comes 60+ frames after the hit.
5. boss_alive dropped in the FIRE-entry frame: no pulse, IDLE and busy=0 next frame. Reset_n=0 mid-GAP clears all outputs to 0 at that edge.
6. With BOSS_ATTACK_RAMP_EN and volley_count=5: cooldown is 40 frames. With volley_count≥12: cooldown is 15 frames.
